// File: rtl/write_back.sv
// Write-back stage register file with a pending-write scoreboard, same-cycle
// bypass from the memory stage, operand stall detection and a retire counter.
module write_back #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en_i,
    input  logic [31:0]     destination_i,
    input  logic [DW-1:0]   wb_data_i,
    input  logic [4:0]      rd_addr_a_i,
    input  logic [4:0]      rd_addr_b_i,
    input  logic            rd_use_a_i,
    input  logic            rd_use_b_i,
    input  logic            rsv_en_i,
    input  logic [4:0]      rsv_idx_i,
    output logic [DW-1:0]   rd_data_a_o,
    output logic [DW-1:0]   rd_data_b_o,
    output logic            stall_o,
    output logic [NREG-1:0] busy_o,
    output logic [31:0]     retire_cnt_o
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [31:0]     retire_cnt_q;
    logic [31:0]     retire_cnt_d;

    logic [4:0] wb_idx;
    logic       hit_a;
    logic       hit_b;
    logic       unused_dest_hi;

    assign wb_idx         = destination_i[4:0];
    assign unused_dest_hi = ^destination_i[31:5];

    always_comb begin
        regs_d = regs_q;
        if (wb_en_i && wb_idx != 5'd0) begin
            regs_d[wb_idx] = wb_data_i;
        end
    end

    // Clear first so that a new reservation of the retiring index wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_idx] = 1'b0;
        end
        if (rsv_en_i && rsv_idx_i != 5'd0) begin
            busy_d[rsv_idx_i] = 1'b1;
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q + (wb_en_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // A write that reset is about to discard is not forwarded either.
    always_comb begin
        hit_a = !rst && wb_en_i && (wb_idx == rd_addr_a_i) && (rd_addr_a_i != 5'd0);
        hit_b = !rst && wb_en_i && (wb_idx == rd_addr_b_i) && (rd_addr_b_i != 5'd0);

        rd_data_a_o = hit_a ? wb_data_i : regs_q[rd_addr_a_i];
        rd_data_b_o = hit_b ? wb_data_i : regs_q[rd_addr_b_i];
        if (rd_addr_a_i == 5'd0) begin
            rd_data_a_o = '0;
        end
        if (rd_addr_b_i == 5'd0) begin
            rd_data_b_o = '0;
        end

        stall_o = (rd_use_a_i && busy_q[rd_addr_a_i] && !hit_a) ||
                  (rd_use_b_i && busy_q[rd_addr_b_i] && !hit_b);
    end

    assign busy_o       = busy_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios plus a randomized run
// checked against a behavioural register-file/scoreboard model.
module tb_write_back;

    logic        clk;
    logic        rst;
    logic        wb_en_i;
    logic [31:0] destination_i;
    logic [31:0] wb_data_i;
    logic [4:0]  rd_addr_a_i;
    logic [4:0]  rd_addr_b_i;
    logic        rd_use_a_i;
    logic        rd_use_b_i;
    logic        rsv_en_i;
    logic [4:0]  rsv_idx_i;
    logic [31:0] rd_data_a_o;
    logic [31:0] rd_data_b_o;
    logic        stall_o;
    logic [31:0] busy_o;
    logic [31:0] retire_cnt_o;

    int tests_run;
    int tests_failed;

    logic [31:0] ref_regs [32];
    logic [31:0] ref_busy;
    logic [31:0] ref_cnt;

    write_back #(.NREG(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en_i       (wb_en_i),
        .destination_i (destination_i),
        .wb_data_i     (wb_data_i),
        .rd_addr_a_i   (rd_addr_a_i),
        .rd_addr_b_i   (rd_addr_b_i),
        .rd_use_a_i    (rd_use_a_i),
        .rd_use_b_i    (rd_use_b_i),
        .rsv_en_i      (rsv_en_i),
        .rsv_idx_i     (rsv_idx_i),
        .rd_data_a_o   (rd_data_a_o),
        .rd_data_b_o   (rd_data_b_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .retire_cnt_o  (retire_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, apply the architectural rules to the model,
    // and return at the following falling edge ready for new stimulus.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = '0;
            ref_busy = '0;
            ref_cnt  = '0;
        end else begin
            if (wb_en_i) begin
                ref_cnt = ref_cnt + 1;
                if (destination_i[4:0] != 0) ref_regs[destination_i[4:0]] = wb_data_i;
                ref_busy[destination_i[4:0]] = 1'b0;
            end
            if (rsv_en_i && rsv_idx_i != 0) ref_busy[rsv_idx_i] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_en_i = 0; destination_i = '0; wb_data_i = '0;
        rd_addr_a_i = '0; rd_addr_b_i = '0; rd_use_a_i = 0; rd_use_b_i = 0;
        rsv_en_i = 0; rsv_idx_i = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); tick(); rst = 0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (!rst && wb_en_i && destination_i[4:0] == a) return wb_data_i;
        return ref_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic sa, sb;
        sa = rd_use_a_i && ref_busy[rd_addr_a_i] && !(!rst && wb_en_i && rd_addr_a_i != 0 && destination_i[4:0] == rd_addr_a_i);
        sb = rd_use_b_i && ref_busy[rd_addr_b_i] && !(!rst && wb_en_i && rd_addr_b_i != 0 && destination_i[4:0] == rd_addr_b_i);
        return sa || sb;
    endfunction

    task automatic test_reset();
        do_reset();
        rd_addr_a_i = 5; rd_addr_b_i = 31; rd_use_a_i = 1; rd_use_b_i = 1;
        #1;
        tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %h expected %h", busy_o, 32'h0); end
        tests_run++; if (retire_cnt_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %h expected %h", retire_cnt_o, 32'h0); end
        tests_run++; if (rd_data_a_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rd_a: got %h expected %h", rd_data_a_o, 32'h0); end
        tests_run++; if (rd_data_b_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rd_b: got %h expected %h", rd_data_b_o, 32'h0); end
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        wb_en_i = 1; destination_i = 32'h0000_0005; wb_data_i = 32'hDEAD_BEEF;
        tick();
        idle_inputs(); rd_addr_a_i = 5;
        #1;
        tests_run++; if (rd_data_a_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL write_read_data: got %h expected %h", rd_data_a_o, 32'hDEAD_BEEF); end
        tests_run++; if (retire_cnt_o !== 32'd1) begin tests_failed++; $display("[TB] FAIL write_read_cnt: got %h expected %h", retire_cnt_o, 32'd1); end
        idle_inputs();
    endtask

    task automatic test_r0();
        do_reset();
        wb_en_i = 1; destination_i = 32'h0; wb_data_i = 32'h1234_5678; rd_addr_a_i = 0;
        #1;
        tests_run++; if (rd_data_a_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL r0_bypass: got %h expected %h", rd_data_a_o, 32'h0); end
        tick();
        idle_inputs(); rd_addr_a_i = 0;
        #1;
        tests_run++; if (rd_data_a_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL r0_read: got %h expected %h", rd_data_a_o, 32'h0); end
        tests_run++; if (retire_cnt_o !== 32'd1) begin tests_failed++; $display("[TB] FAIL r0_cnt: got %h expected %h", retire_cnt_o, 32'd1); end
        tests_run++; if (busy_o[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL r0_busy: got %b expected 0", busy_o[0]); end
        idle_inputs();
    endtask

    task automatic test_bypass_stall();
        do_reset();
        rsv_en_i = 1; rsv_idx_i = 7;
        tick();
        idle_inputs(); rd_use_a_i = 1; rd_addr_a_i = 7;
        #1;
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_busy: got %b expected 1", stall_o); end
        tick();
        wb_en_i = 1; destination_i = 32'd7; wb_data_i = 32'hFFFF_FF80;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_release: got %b expected 0", stall_o); end
        tests_run++; if (rd_data_a_o !== 32'hFFFF_FF80) begin tests_failed++; $display("[TB] FAIL bypass_data: got %h expected %h", rd_data_a_o, 32'hFFFF_FF80); end
        tick();
        idle_inputs(); rd_addr_a_i = 7;
        #1;
        tests_run++; if (busy_o[7] !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy7_cleared: got %b expected 0", busy_o[7]); end
        tests_run++; if (rd_data_a_o !== 32'hFFFF_FF80) begin tests_failed++; $display("[TB] FAIL r7_stored: got %h expected %h", rd_data_a_o, 32'hFFFF_FF80); end
        idle_inputs();
    endtask

    task automatic test_set_clear();
        do_reset();
        rsv_en_i = 1; rsv_idx_i = 4;
        tick();
        rsv_en_i = 1; rsv_idx_i = 6; wb_en_i = 1; destination_i = 32'd4; wb_data_i = 32'h44;
        tick();
        idle_inputs();
        #1;
        tests_run++; if (busy_o !== 32'h0000_0040) begin tests_failed++; $display("[TB] FAIL set_clear_diff: got %h expected %h", busy_o, 32'h40); end
        rsv_en_i = 1; rsv_idx_i = 9; wb_en_i = 1; destination_i = 32'd9; wb_data_i = 32'h99;
        tick();
        idle_inputs(); rd_addr_b_i = 9;
        #1;
        tests_run++; if (busy_o !== 32'h0000_0240) begin tests_failed++; $display("[TB] FAIL set_wins: got %h expected %h", busy_o, 32'h240); end
        tests_run++; if (rd_data_b_o !== 32'h99) begin tests_failed++; $display("[TB] FAIL set_clear_data: got %h expected %h", rd_data_b_o, 32'h99); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        ref_cnt = 32'hFFFF_FFFF;
        #1;
        tests_run++; if (retire_cnt_o !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL wrap_preload: got %h expected %h", retire_cnt_o, 32'hFFFF_FFFF); end
        wb_en_i = 1; destination_i = 32'd12; wb_data_i = 32'h0BAD_F00D;
        tick();
        idle_inputs();
        #1;
        tests_run++; if (retire_cnt_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_cnt: got %h expected %h", retire_cnt_o, 32'h0); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_en_i = 1; destination_i = 32'd8; wb_data_i = 32'hA5;
        tick();
        idle_inputs(); rsv_en_i = 1; rsv_idx_i = 8;
        tick();
        rsv_idx_i = 9;
        tick();
        idle_inputs(); rd_addr_a_i = 8;
        #1;
        tests_run++; if (busy_o !== 32'h0000_0300) begin tests_failed++; $display("[TB] FAIL mid_busy_pre: got %h expected %h", busy_o, 32'h300); end
        tests_run++; if (rd_data_a_o !== 32'hA5) begin tests_failed++; $display("[TB] FAIL mid_r8_pre: got %h expected %h", rd_data_a_o, 32'hA5); end
        rst = 1; wb_en_i = 1; destination_i = 32'd8; wb_data_i = 32'h55; rsv_en_i = 1; rsv_idx_i = 10;
        tick();
        rst = 0; idle_inputs(); rd_addr_a_i = 8;
        #1;
        tests_run++; if (rd_data_a_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_r8_post: got %h expected %h", rd_data_a_o, 32'h0); end
        tests_run++; if (busy_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_busy_post: got %h expected %h", busy_o, 32'h0); end
        tests_run++; if (retire_cnt_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_cnt_post: got %h expected %h", retire_cnt_o, 32'h0); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        logic        es;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            wb_en_i       = $urandom_range(0, 1);
            destination_i = {$urandom(), 5'd0} | 32'($urandom_range(0, 9));
            wb_data_i     = $urandom();
            rd_addr_a_i   = 5'($urandom_range(0, 9));
            rd_addr_b_i   = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 9));
            rd_use_a_i    = $urandom_range(0, 1);
            rd_use_b_i    = $urandom_range(0, 1);
            rsv_en_i      = $urandom_range(0, 1);
            rsv_idx_i     = 5'($urandom_range(0, 9));
            #1;
            ea = exp_read(rd_addr_a_i);
            eb = exp_read(rd_addr_b_i);
            es = exp_stall();
            tests_run++; if (rd_data_a_o !== ea) begin tests_failed++; $display("[TB] FAIL rand_rd_a[%0d]: got %h expected %h", n, rd_data_a_o, ea); end
            tests_run++; if (rd_data_b_o !== eb) begin tests_failed++; $display("[TB] FAIL rand_rd_b[%0d]: got %h expected %h", n, rd_data_b_o, eb); end
            tests_run++; if (stall_o !== es) begin tests_failed++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, stall_o, es); end
            tests_run++; if (busy_o !== ref_busy) begin tests_failed++; $display("[TB] FAIL rand_busy[%0d]: got %h expected %h", n, busy_o, ref_busy); end
            tests_run++; if (retire_cnt_o !== ref_cnt) begin tests_failed++; $display("[TB] FAIL rand_cnt[%0d]: got %h expected %h", n, retire_cnt_o, ref_cnt); end
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1;
        idle_inputs();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        ref_busy = '0;
        ref_cnt  = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_r0();
        test_bypass_stall();
        test_set_clear();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter NREG, default 32, is the number of general registers (r0..r31); the index width is 5 bits.
REQ-002 Parameter DW, default 32, is the register and data width in bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port wb_en_i, input, 1: a write-back from the memory stage is valid this cycle.
REQ-006 Port destination_i, input, 32: the destination descriptor from the memory stage; bits [4:0] are the register index and bits [31:5] are ignored.
REQ-007 Port wb_data_i, input, 32: the write-back data from the memory stage (already sign- or zero-extended).
REQ-008 Port rd_addr_a_i, input, 5: read port A register index.
REQ-009 Port rd_addr_b_i, input, 5: read port B register index.
REQ-010 Port rd_use_a_i, input, 1: decode consumes port A this cycle.
REQ-011 Port rd_use_b_i, input, 1: decode consumes port B this cycle.
REQ-012 Port rsv_en_i, input, 1: decode issues an instruction that will write rsv_idx_i.
REQ-013 Port rsv_idx_i, input, 5: the register being reserved.
REQ-014 Port rd_data_a_o, output, 32: read port A data.
REQ-015 Port rd_data_b_o, output, 32: read port B data.
REQ-016 Port stall_o, output, 1: decode must hold; the operand is not yet available.
REQ-017 Port busy_o, output, 32: the pending-write scoreboard, one bit per register.
REQ-018 Port retire_cnt_o, output, 32: the count of committed register writes.

Function
REQ-019 The block SHALL hold a register array of NREG x DW bits.
REQ-020 Register write: on a rising edge with wb_en_i=1, rst=0 and destination_i[4:0]!=0, regs[destination_i[4:0]] SHALL become wb_data_i.
REQ-021 Writes to r0 SHALL be discarded; r0 SHALL always read 0 and SHALL never be busy.
REQ-022 Read ports SHALL be combinational, with zero-cycle latency.
REQ-023 Bypass: if wb_en_i=1, destination_i[4:0]==rd_addr_x_i and rd_addr_x_i!=0, then rd_data_x_o SHALL equal wb_data_i in that same cycle.
REQ-024 Scoreboard set: on a rising edge with rsv_en_i=1 and rsv_idx_i!=0, busy[rsv_idx_i] SHALL be set to 1.
REQ-025 Scoreboard clear: on a rising edge with wb_en_i=1, busy[destination_i[4:0]] SHALL be cleared to 0.
REQ-026 When set and clear target the same index on the same edge, the set SHALL win, because a newer producer is in flight.
REQ-027 When set and clear target different indices on the same edge, both SHALL take effect.
REQ-028 stall_o SHALL be 1 when, for either port x, rd_use_x_i=1, busy[rd_addr_x_i]=1, and no same-cycle bypass hit exists for that port (REQ-023); otherwise stall_o SHALL be 0.
REQ-029 stall_o SHALL be purely combinational and SHALL NOT gate rsv_en_i internally; decode is responsible for withholding rsv_en_i while stalled.
REQ-030 retire_cnt_o SHALL increment by 1 on each rising edge with wb_en_i=1 and rst=0, including writes to r0.
REQ-031 retire_cnt_o SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-032 wb_en_i for a register that is not busy SHALL still write and count, and the clear SHALL have no effect.

Reset
REQ-033 On a rising edge with rst=1, all registers, busy_o and retire_cnt_o SHALL become 0.
REQ-034 While rst=1, wb_en_i and rsv_en_i SHALL be ignored, even mid-operation.
REQ-035 During rst=1, rd_data_x_o and stall_o SHALL remain combinational from current state; after the reset edge they SHALL read 0.
REQ-036 After rst deasserts, a write SHALL be accepted on the first edge.

Verification
REQ-037 Write then read: wb_en_i=1, destination_i=0x00000005, wb_data_i=0xDEADBEEF; next cycle rd_addr_a_i=5 -> rd_data_a_o=0xDEADBEEF and retire_cnt_o=1.
REQ-038 r0 write and bypass: wb_en_i=1, destination_i=0, wb_data_i=0x12345678, rd_addr_a_i=0 -> rd_data_a_o=0 both in that cycle and the next; retire_cnt_o=1.
REQ-039 Bypass and stall release: reserve r7, then wait one cycle with rd_use_a_i=1 and rd_addr_a_i=7 -> stall_o=1; then wb_en_i=1, dest=7, data=0xFFFFFF80 -> in the same cycle stall_o=0 and rd_data_a_o=0xFFFFFF80; next cycle busy_o[7]=0.
REQ-040 Simultaneous set and clear: rsv_en_i=1, rsv_idx_i=9 together with wb_en_i=1, dest=9 on the same edge -> busy_o[9]=1 afterwards and regs[9] is updated.
REQ-041 Counter wrap: drive 2^32 writes, or force the counter to 0xFFFFFFFF, then one more write -> retire_cnt_o=0.
REQ-042 Reset mid-operation: busy_o=0x00000300 and regs[8]=0xA5, then rst=1 with wb_en_i=1, dest=8, data=0x55 -> after the edge regs[8]=0, busy_o=0, retire_cnt_o=0.
